// File: rtl/sram_fifo_ctrl_if.sv
// Stream and SRAM-port bundle for sram_fifo_ctrl.
// The slave modport is the FIFO controller itself. The master modport is the
// environment: the producer/consumer and the dual-port SRAM it drives.
interface sram_fifo_ctrl_if #(
    parameter int SRAM_DEPTH_BIT = 6,
    parameter int SRAM_WIDTH     = 28
);
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [SRAM_WIDTH-1:0]     in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SRAM_WIDTH-1:0]     out_data;
    logic [SRAM_DEPTH_BIT+1:0] count;
    logic                      sram_write_en;
    logic [SRAM_DEPTH_BIT-1:0] sram_addr_w;
    logic [SRAM_WIDTH-1:0]     sram_data_in;
    logic                      sram_read_en;
    logic [SRAM_DEPTH_BIT-1:0] sram_addr_r;
    logic [SRAM_WIDTH-1:0]     sram_data_out;

    modport slave (
        input  flush, in_valid, in_data, out_ready, sram_data_out,
        output in_ready, out_valid, out_data, count,
        output sram_write_en, sram_addr_w, sram_data_in,
        output sram_read_en, sram_addr_r
    );

    modport master (
        output flush, in_valid, in_data, out_ready, sram_data_out,
        input  in_ready, out_valid, out_data, count,
        input  sram_write_en, sram_addr_w, sram_data_in,
        input  sram_read_en, sram_addr_r
    );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller in front of an external dual-port SRAM with one-cycle read latency.
// Words are written straight into the SRAM. They are read back into a
// two-entry output buffer (head + skid), so a pop and a returning read can
// overlap every cycle without a bubble. At most one SRAM read is in flight.
module sram_fifo_ctrl #(
    parameter int SRAM_DEPTH_BIT = 6,
    parameter int SRAM_DEPTH     = 2 ** SRAM_DEPTH_BIT,
    parameter int SRAM_WIDTH     = 28
) (
    input  logic               clk,
    input  logic               rst,
    sram_fifo_ctrl_if.slave    bus
);
    localparam int UW = SRAM_DEPTH_BIT + 1;
    localparam int CW = SRAM_DEPTH_BIT + 2;

    logic [SRAM_DEPTH_BIT-1:0] wptr;
    logic [SRAM_DEPTH_BIT-1:0] rptr;
    logic [UW-1:0]             unread;
    logic                      rd_pend;
    logic [1:0]                buf_cnt;
    logic [SRAM_WIDTH-1:0]     head_q;
    logic [SRAM_WIDTH-1:0]     skid_q;

    logic                      push_fire;
    logic                      pop_fire;
    logic                      read_issue;
    logic [2:0]                occ_after;

    // Pointer advance with wrap at SRAM_DEPTH (also correct for non power-of-two depths).
    function automatic logic [SRAM_DEPTH_BIT-1:0] next_ptr(input logic [SRAM_DEPTH_BIT-1:0] p);
        if (p == SRAM_DEPTH_BIT'(SRAM_DEPTH - 1))
            return '0;
        else
            return p + 1'b1;
    endfunction

    // Handshakes and read issue. The buffer plus the in-flight read must stay
    // within two entries, counted after this cycle's pop.
    always_comb begin
        bus.in_ready  = (unread != UW'(SRAM_DEPTH)) & ~bus.flush;
        bus.out_valid = (buf_cnt != 2'd0);
        push_fire     = bus.in_valid & bus.in_ready & ~rst;
        pop_fire      = bus.out_valid & bus.out_ready;
        occ_after     = {1'b0, buf_cnt} + {2'b00, rd_pend} - {2'b00, pop_fire};
        read_issue    = (unread != '0) & (occ_after < 3'd2) & ~bus.flush & ~rst;
    end

    assign bus.sram_write_en = push_fire;
    assign bus.sram_addr_w   = wptr;
    assign bus.sram_data_in  = bus.in_data;
    assign bus.sram_read_en  = read_issue;
    assign bus.sram_addr_r   = rptr;
    assign bus.out_data      = head_q;
    assign bus.count         = CW'(unread) + CW'(rd_pend) + CW'(buf_cnt);

    // Control state: pointers, SRAM occupancy, in-flight flag and buffer fill.
    // Both reset and flush clear it, which also drops a read that returns next cycle.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wptr    <= '0;
            rptr    <= '0;
            unread  <= '0;
            rd_pend <= 1'b0;
            buf_cnt <= 2'd0;
        end else begin
            if (push_fire)
                wptr <= next_ptr(wptr);
            if (read_issue)
                rptr <= next_ptr(rptr);
            unread  <= unread + UW'(push_fire) - UW'(read_issue);
            rd_pend <= read_issue;
            buf_cnt <= buf_cnt + 2'(rd_pend) - 2'(pop_fire);
        end
    end

    // Output buffer data. Returning SRAM words fill the tail. A pop shifts skid into head.
    // It is not reset: buf_cnt alone says which entries hold data.
    always_ff @(posedge clk) begin
        if (pop_fire && rd_pend) begin
            if (buf_cnt == 2'd2) begin
                head_q <= skid_q;
                skid_q <= bus.sram_data_out;
            end else begin
                head_q <= bus.sram_data_out;
            end
        end else if (pop_fire) begin
            head_q <= skid_q;
        end else if (rd_pend) begin
            if (buf_cnt == 2'd0)
                head_q <= bus.sram_data_out;
            else
                skid_q <= bus.sram_data_out;
        end
    end
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Testbench for sram_fifo_ctrl.
// The first part is a cycle table of hand-computed vectors. The second part
// is a set of multi-cycle sequences (fill, stream, backpressure, flush,
// reset), which are checked against a queue model of the FIFO contents.
module tb_sram_fifo_ctrl;
    localparam int DB    = 6;
    localparam int W     = 28;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   pop_cnt = 0;
    logic [W-1:0] q[$];
    logic [W-1:0] mem [DEPTH];

    always #5 clk = ~clk;

    sram_fifo_ctrl_if #(.SRAM_DEPTH_BIT(DB), .SRAM_WIDTH(W)) bus ();

    sram_fifo_ctrl #(.SRAM_DEPTH_BIT(DB), .SRAM_DEPTH(DEPTH), .SRAM_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Dual-port SRAM model: the read data is registered and valid one cycle after sram_read_en.
    always @(posedge clk) begin
        if (bus.sram_write_en)
            mem[bus.sram_addr_w] <= bus.sram_data_in;
        if (bus.sram_read_en)
            bus.sram_data_out <= mem[bus.sram_addr_r];
    end

    typedef struct {
        logic          vld;
        logic [W-1:0]  d;
        logic          ordy;
        logic          e_wr;
        logic [DB-1:0] e_wa;
        logic          e_rd;
        logic [DB-1:0] e_ra;
        logic          e_ov;
        logic [W-1:0]  e_od;
        logic [7:0]    e_cnt;
        logic          e_ir;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle. Drive on the falling edge, sample 1 time unit later,
    // and update the queue model on each accepted push and pop.
    task automatic cyc(input logic vld, input logic [W-1:0] d, input logic ordy, input logic fl);
        logic pop;
        logic acc;
        @(negedge clk);
        bus.in_valid  = vld;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #1;
        check("count_model", 64'(bus.count), 64'(q.size()));
        check("wr_en_accept", 64'(bus.sram_write_en), 64'(vld & bus.in_ready));
        check("occ_le_2", 64'(({1'b0, dut.buf_cnt} + {2'b00, dut.rd_pend}) <= 3'd2), 64'd1);
        if (fl) begin
            check("flush_no_rd", 64'(bus.sram_read_en), 64'd0);
            check("flush_no_wr", 64'(bus.sram_write_en), 64'd0);
        end
        pop = bus.out_valid & ordy;
        if (pop) begin
            pop_cnt++;
            if (q.size() == 0)
                check("pop_when_empty", 64'(bus.out_data), 64'hDEAD);
            else
                check("out_order", 64'(bus.out_data), 64'(q.pop_front()));
        end
        acc = vld & bus.in_ready;
        if (acc)
            q.push_back(d);
        @(posedge clk);
        if (fl)
            q.delete();
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++)
            cyc(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            cyc(1'b0, '0, 1'b1, 1'b0);
        check("drain_done", 64'(q.size()), 64'd0);
        check("drain_ov", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // {vld, data, ordy, e_wr, e_wa, e_rd, e_ra, e_ov, e_od, e_cnt, e_ir}
        tbl[0]  = '{1'b1, 28'h0ABCDEF, 1'b1, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 28'h0, 8'd0, 1'b1};
        tbl[1]  = '{1'b0, 28'h0,       1'b1, 1'b0, 6'd0, 1'b1, 6'd0, 1'b0, 28'h0, 8'd1, 1'b1};
        tbl[2]  = '{1'b0, 28'h0,       1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 28'h0, 8'd1, 1'b1};
        tbl[3]  = '{1'b0, 28'h0,       1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 28'h0ABCDEF, 8'd1, 1'b1};
        tbl[4]  = '{1'b0, 28'h0,       1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 28'h0, 8'd0, 1'b1};
        tbl[5]  = '{1'b1, 28'h1111111, 1'b0, 1'b1, 6'd1, 1'b0, 6'd0, 1'b0, 28'h0, 8'd0, 1'b1};
        tbl[6]  = '{1'b1, 28'h2222222, 1'b0, 1'b1, 6'd2, 1'b1, 6'd1, 1'b0, 28'h0, 8'd1, 1'b1};
        tbl[7]  = '{1'b0, 28'h0,       1'b0, 1'b0, 6'd0, 1'b1, 6'd2, 1'b0, 28'h0, 8'd2, 1'b1};
        tbl[8]  = '{1'b0, 28'h0,       1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 28'h1111111, 8'd2, 1'b1};
        tbl[9]  = '{1'b0, 28'h0,       1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 28'h1111111, 8'd2, 1'b1};
        tbl[10] = '{1'b0, 28'h0,       1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 28'h2222222, 8'd1, 1'b1};
        tbl[11] = '{1'b0, 28'h0,       1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 28'h0, 8'd0, 1'b1};

        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset: the SRAM strobes stay low while rst is high, and the block is empty afterwards.
        @(negedge clk);
        bus.in_valid = 1'b1;
        @(negedge clk);
        #1;
        check("rst_no_wr", 64'(bus.sram_write_en), 64'd0);
        check("rst_no_rd", 64'(bus.sram_read_en), 64'd0);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);

        // Cycle table: a single word with 3-cycle latency, then two words with a skid fill.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.in_valid  = tbl[i].vld;
            bus.in_data   = tbl[i].d;
            bus.out_ready = tbl[i].ordy;
            bus.flush     = 1'b0;
            #1;
            check($sformatf("v%0d_wr_en", i), 64'(bus.sram_write_en), 64'(tbl[i].e_wr));
            check($sformatf("v%0d_rd_en", i), 64'(bus.sram_read_en), 64'(tbl[i].e_rd));
            check($sformatf("v%0d_out_valid", i), 64'(bus.out_valid), 64'(tbl[i].e_ov));
            check($sformatf("v%0d_count", i), 64'(bus.count), 64'(tbl[i].e_cnt));
            check($sformatf("v%0d_in_ready", i), 64'(bus.in_ready), 64'(tbl[i].e_ir));
            if (tbl[i].e_wr)
                check($sformatf("v%0d_addr_w", i), 64'(bus.sram_addr_w), 64'(tbl[i].e_wa));
            if (tbl[i].e_rd)
                check($sformatf("v%0d_addr_r", i), 64'(bus.sram_addr_r), 64'(tbl[i].e_ra));
            if (tbl[i].e_ov)
                check($sformatf("v%0d_out_data", i), 64'(bus.out_data), 64'(tbl[i].e_od));
            @(posedge clk);
        end

        // Fill: 70 push attempts with out_ready low. Capacity is 64 in SRAM plus 2 buffered.
        for (int i = 0; i < 70; i++)
            cyc(1'b1, W'(32'h200 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, '0, 1'b0, 1'b0);
        #2;
        check("fill_count", 64'(bus.count), 64'd66);
        check("fill_in_ready", 64'(bus.in_ready), 64'd0);
        check("fill_unread", 64'(dut.unread), 64'd64);
        check("fill_head", 64'(bus.out_data), 64'h200);
        drain();

        // Streaming: 200 words with continuous push and pop. One pop per cycle from cycle 3 on.
        pop_cnt = 0;
        for (int i = 0; i < 200; i++)
            cyc(1'b1, W'(32'h1000 + i), 1'b1, 1'b0);
        check("stream_pops", 64'(pop_cnt), 64'd197);
        drain();

        // Backpressure: random out_ready (about 30%) with continuous push.
        for (int i = 0; i < 300; i++)
            cyc(1'b1, W'(32'h2000 + i), 1'(($urandom_range(0, 99)) < 30), 1'b0);
        drain();

        // Flush while a read is in flight with 5 words held.
        for (int i = 0; i < 5; i++)
            cyc(1'b1, W'(32'h300 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 28'h305, 1'b1, 1'b0);
        #2;
        check("fl_rd_pend", 64'(dut.rd_pend), 64'd1);
        check("fl_count_pre", 64'(bus.count), 64'd5);
        cyc(1'b1, 28'h306, 1'b0, 1'b1);
        #2;
        check("fl_count_post", 64'(bus.count), 64'd0);
        check("fl_out_valid", 64'(bus.out_valid), 64'd0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 28'h5A5A5A5, 1'b0, 1'b0);
        cyc(1'b1, 28'h5A5A5A6, 1'b0, 1'b0);
        drain();

        // Reset mid-stream: count 10 with a read in flight.
        for (int i = 0; i < 11; i++)
            cyc(1'b1, W'(32'h400 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        #2;
        check("mr_count_pre", 64'(bus.count), 64'd10);
        check("mr_rd_pend", 64'(dut.rd_pend), 64'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst           = 1'b1;
            bus.in_valid  = 1'b1;
            bus.in_data   = 28'h777;
            bus.out_ready = 1'b1;
            #1;
            check("mr_no_wr", 64'(bus.sram_write_en), 64'd0);
            check("mr_no_rd", 64'(bus.sram_read_en), 64'd0);
        end
        @(negedge clk);
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("mr_count", 64'(bus.count), 64'd0);
        check("mr_out_valid", 64'(bus.out_valid), 64'd0);
        check("mr_in_ready", 64'(bus.in_ready), 64'd1);
        q.delete();
        @(posedge clk);
        cyc(1'b1, 28'h0F00D01, 1'b0, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
